systolic_input_feeder: RTL and testbench
========================================

Name: systolic_input_feeder

Overview:
Parametrised successor to the fixed 4x4 input RAM feeding the systolic array's west edge. It stores ROWS operand rows of up to K_MAX words each. On a start handshake it streams them with the diagonal skew generated in hardware: row r is delayed r cycles, and zero padding is inserted rather than stored. A hold input stalls the stream, and busy/done report sequencing to the array controller.

Parameters:
ROWS, 4, number of array rows / output channels
DATA_W, 16, operand width in bits
K_MAX, 4, maximum words per row (buffer depth per row)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe for the load port
wr_row  in  $clog2(ROWS)  target row of write
wr_col  in  $clog2(K_MAX)  target column (word index) of write
wr_data  in  DATA_W  write data
wr_rej  out  1  one-cycle pulse: write dropped because feeder not IDLE
start  in  1  begin stream; sampled only in IDLE
k_len  in  $clog2(K_MAX+1)  words per row for this stream; sampled with start
hold  in  1  stall: freeze stream position and outputs
busy  out  1  high in STREAM and DONE
done  out  1  one-cycle pulse after the last valid beat
q_valid  out  1  q holds a new beat this cycle
q  out  ROWS*DATA_W  skewed row outputs; row r in bits [r*DATA_W +: DATA_W]

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; q=0, q_valid=0, busy=0, done=0, wr_rej=0; beat counter=0. Storage array is not reset; contents are retained across rst_n.
- Writes: in IDLE, wr_en stores wr_data at [wr_row][wr_col] on the clock edge. Out-of-range wr_row or wr_col is dropped silently.
- Writes in STREAM or DONE are dropped and raise wr_rej the next cycle.
- States and transitions:
  - IDLE: on an edge with start=1, latch L = min(k_len, K_MAX) + ROWS - 1.
    - k_len=0: go to DONE; q stays 0.
    - otherwise: go to STREAM, t=0, q loaded with beat 0.
  - STREAM: q_valid = ~hold (combinational from the state register and hold).
    - Edge with hold=0 and t<L-1: t++, q loaded with beat t+1.
    - Edge with hold=0 and t==L-1: go to DONE, q<=0.
    - hold=1: t and q frozen.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored outside IDLE.
- Beat t, row r: q[r] = mem[r][t-r] if 0 <= t-r < k_len, else 0.
- Latency: first valid beat appears in the cycle after the edge that samples start. With no hold, a stream has exactly L valid beats and done is high in the cycle after the last beat.
- k_len > K_MAX is clamped to K_MAX.
- Simultaneous wr_en and start in IDLE: the write is committed and the stream starts. The stream reads the newly written value.
- rst_n asserted mid-stream: outputs zeroed immediately, no done pulse, next start begins a fresh stream.

Decomposition:
- Package systolic_feeder_pkg:
  - state enum IDLE/STREAM/DONE
  - width helper functions for counter, row and column fields
- Natural sub-module skew_row_buf, instantiated ROWS times via generate. Each instance holds the K_MAX x DATA_W storage, a write port, and a zero-gated read of index t-r with a constant row offset parameter.
- Top level holds the FSM, beat counter, hold gating and output registers.

Test Plan:
- Reset: rst_n low, then high with no stimulus -> q=0, q_valid=0, busy=0, done=0.
- Full skew, ROWS=4, K_MAX=4: load mem[r][c]=16'h00rc, start k_len=4 -> 7 valid beats, with data per beat:
  - beat0: q0=0000, q1..q3=0
  - beat3: q0=0003, q1=0012, q2=0021, q3=0030
  - beat6: q3=0033, others 0
  - done pulses the next cycle.
- Short and zero lengths:
  - k_len=2 -> 5 valid beats; beat4: q3=0031, others 0.
  - k_len=0 -> done one cycle after start, q_valid never high.
  - k_len=7 -> behaves as k_len=4.
- Hold: k_len=4, hold high for 3 cycles starting at beat 2 -> q frozen at the beat-2 values, q_valid low, then stream resumes; total valid beats 7, done delayed 3 cycles.
- Busy protection: wr_en to [1][1] during STREAM -> wr_rej pulse and data unchanged on the next stream; start during STREAM/DONE ignored.
- Mid-stream reset: rst_n low at beat 3 -> outputs 0 immediately and no done pulse; restart with k_len=4 reproduces the full-skew sequence (storage retained).

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared types and width helpers for the systolic input feeder.
package systolic_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Index width for a field addressing n entries (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold a length from 0 to k inclusive.
  function automatic int len_w(input int k);
    return $clog2(k + 1);
  endfunction

  // Beat counter width: the last beat index is k + r - 2.
  function automatic int cnt_w(input int k, input int r);
    return (k + r > 2) ? $clog2(k + r) : 1;
  endfunction

endpackage

// File: rtl/skew_row_buf.sv
// One operand row: K_MAX-word store plus a skewed, zero-gated read.
// The read selects word (beat - ROW_OFF) when that falls inside [0, len),
// otherwise returns zero, so skew padding is never stored.
module skew_row_buf
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int K_MAX   = 4,
  parameter int ROW_OFF = 0,
  parameter int CNT_W   = 3,
  parameter int COL_W   = 2,
  parameter int LEN_W   = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-1:0]  beat,
  input  logic [LEN_W-1:0]  len,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [K_MAX];

  // Storage write; columns beyond K_MAX match no slot and are dropped.
  always_ff @(posedge clk) begin
    for (int c = 0; c < K_MAX; c++) begin
      if (we && (wr_col == COL_W'(c))) mem[c] <= wr_data;
    end
  end

  // Skewed read with same-cycle write forwarding, so a stream started on the
  // edge that writes a word sees the new value.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < K_MAX; c++) begin
      if ((beat == CNT_W'(ROW_OFF + c)) && (LEN_W'(c) < len)) begin
        rd_data = (we && (wr_col == COL_W'(c))) ? wr_data : mem[c];
      end
    end
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// West-edge operand feeder for the systolic array: stores ROWS rows of up
// to K_MAX words and streams them with a hardware-generated diagonal skew.
//
// Handshake: start is a single-cycle request honoured only in IDLE (no ready
// is returned; busy tells the controller a request would be ignored).
// q_valid marks q as a fresh beat and is low whenever hold is high, and hold
// freezes both the beat position and q.
module systolic_input_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int DATA_W = 16,
  parameter int K_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [idx_w(ROWS)-1:0]        wr_row,
  input  logic [idx_w(K_MAX)-1:0]       wr_col,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          wr_rej,
  input  logic                          start,
  input  logic [len_w(K_MAX)-1:0]       k_len,
  input  logic                          hold,
  output logic                          busy,
  output logic                          done,
  output logic                          q_valid,
  output logic [ROWS*DATA_W-1:0]        q
);

  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(K_MAX);
  localparam int LEN_W = len_w(K_MAX);
  localparam int CNT_W = cnt_w(K_MAX, ROWS);

  state_t                  state;
  logic [CNT_W-1:0]        t;
  logic [CNT_W-1:0]        last;
  logic [LEN_W-1:0]        k_reg;
  logic [LEN_W-1:0]        k_clamp;
  logic [LEN_W-1:0]        len_sel;
  logic [CNT_W-1:0]        beat_nxt;
  logic [ROWS-1:0]         row_we;
  logic [ROWS*DATA_W-1:0]  q_nxt;

  // Clamp the requested length and pick which beat the row buffers compute:
  // beat 0 with the live length while starting, otherwise the next beat.
  always_comb begin
    k_clamp  = (k_len > LEN_W'(K_MAX)) ? LEN_W'(K_MAX) : k_len;
    len_sel  = (state == IDLE) ? k_clamp : k_reg;
    beat_nxt = (state == IDLE) ? '0 : t + CNT_W'(1);
  end

  // Row write enables; loads are accepted only while idle.
  always_comb begin
    row_we = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_we[r] = wr_en && (state == IDLE) && (wr_row == ROW_W'(r));
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_row_buf #(
      .DATA_W  (DATA_W),
      .K_MAX   (K_MAX),
      .ROW_OFF (r),
      .CNT_W   (CNT_W),
      .COL_W   (COL_W),
      .LEN_W   (LEN_W)
    ) u_buf (
      .clk     (clk),
      .we      (row_we[r]),
      .wr_col  (wr_col),
      .wr_data (wr_data),
      .beat    (beat_nxt),
      .len     (len_sel),
      .rd_data (q_nxt[r*DATA_W +: DATA_W])
    );
  end

  // Sequencer: beat counter, output register and reject pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      t      <= '0;
      last   <= '0;
      k_reg  <= '0;
      q      <= '0;
      wr_rej <= 1'b0;
    end else begin
      wr_rej <= wr_en && (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            k_reg <= k_clamp;
            last  <= CNT_W'(k_clamp) + CNT_W'(ROWS - 2);
            t     <= '0;
            if (k_clamp == '0) begin
              state <= DONE;
              q     <= '0;
            end else begin
              state <= STREAM;
              q     <= q_nxt;
            end
          end
        end
        STREAM: begin
          if (!hold) begin
            if (t == last) begin
              state <= DONE;
              q     <= '0;
            end else begin
              t <= t + CNT_W'(1);
              q <= q_nxt;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decoded from the state register.
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    q_valid = (state == STREAM) && !hold;
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Self-checking bench for systolic_input_feeder: directed and randomized
// streams checked against a storage model and the skew rule
// q[r] = mem[r][t-r] when 0 <= t-r < k, else 0.
module tb_systolic_input_feeder;

  localparam int ROWS   = 4;
  localparam int DATA_W = 16;
  localparam int K_MAX  = 4;
  localparam int QW     = ROWS * DATA_W;

  // clock / reset / DUT signals
  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [1:0]        wr_row;
  logic [1:0]        wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              wr_rej;
  logic              start;
  logic [2:0]        k_len;
  logic              hold;
  logic              busy;
  logic              done;
  logic              q_valid;
  logic [QW-1:0]     q;

  int checks   = 0;
  int failures = 0;

  // reference model and scoreboard
  logic [DATA_W-1:0] ref_mem [ROWS][K_MAX];
  logic [QW-1:0]     exp_q[$];
  logic [QW-1:0]     obs_beats[$];
  logic [QW-1:0]     beat3;

  systolic_input_feeder #(
    .ROWS   (ROWS),
    .DATA_W (DATA_W),
    .K_MAX  (K_MAX)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .wr_rej  (wr_rej),
    .start   (start),
    .k_len   (k_len),
    .hold    (hold),
    .busy    (busy),
    .done    (done),
    .q_valid (q_valid),
    .q       (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected beats for a length-k stream, straight from the skew rule.
  task automatic build_expected(input int k);
    int keff;
    int nbeats;
    logic [QW-1:0] b;
    keff   = (k > K_MAX) ? K_MAX : k;
    nbeats = (keff == 0) ? 0 : keff + ROWS - 1;
    exp_q.delete();
    for (int tt = 0; tt < nbeats; tt++) begin
      b = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ((tt - r >= 0) && (tt - r < keff)) b[r*DATA_W +: DATA_W] = ref_mem[r][tt-r];
      end
      exp_q.push_back(b);
    end
  endtask

  // Driver: idle-time write; entered and left just after a rising edge.
  task automatic write_word(input int r, input int c, input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_row  = 2'(r);
    wr_col  = 2'(c);
    wr_data = d;
    ref_mem[r][c] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check_bit("wr_rej_idle", wr_rej, 1'b0);
    @(posedge clk); #1;
  endtask

  // Driver + monitor for one stream. hold is raised for hold_len cycles
  // while q shows beat hold_at; wr_at injects a write at that cycle;
  // poke keeps start high through STREAM and DONE.
  task automatic run_stream(input int k, input int hold_at, input int hold_len,
                            input int wr_at, input bit poke);
    int keff;
    int nbeats;
    int held;
    int cyc;
    int n_valid;
    int done_cyc;
    bit seen_done;
    keff      = (k > K_MAX) ? K_MAX : k;
    nbeats    = (keff == 0) ? 0 : keff + ROWS - 1;
    held      = 0;
    cyc       = 0;
    n_valid   = 0;
    done_cyc  = -1;
    seen_done = 1'b0;
    build_expected(k);
    obs_beats.delete();
    start = 1'b1;
    k_len = 3'(k);
    @(posedge clk); #1;
    if (!poke) start = 1'b0;
    k_len = 3'($urandom_range(0, 7));
    while (!seen_done && cyc < 64) begin
      hold  = 1'b0;
      wr_en = 1'b0;
      if (exp_q.size() > 0 && n_valid == hold_at && held < hold_len) begin
        hold = 1'b1;
        held++;
      end
      if (cyc == wr_at) begin
        wr_en   = 1'b1;
        wr_row  = 2'd1;
        wr_col  = 2'd1;
        wr_data = DATA_W'($urandom);
      end
      @(negedge clk);
      if (wr_at >= 0 && cyc == wr_at + 1) check_bit("wr_rej_busy", wr_rej, 1'b1);
      else check_bit("wr_rej_quiet", wr_rej, 1'b0);
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        check_vec("q_zero_at_done", q, '0);
        check_bit("valid_low_at_done", q_valid, 1'b0);
        check_bit("busy_in_done", busy, 1'b1);
      end else begin
        check_bit("busy_in_stream", busy, 1'b1);
        if (hold) begin
          check_bit("hold_valid_low", q_valid, 1'b0);
          check_vec("hold_q_frozen", q, exp_q[0]);
        end else if (exp_q.size() > 0) begin
          check_bit("beat_valid", q_valid, 1'b1);
          check_vec($sformatf("beat%0d_data", n_valid), q, exp_q.pop_front());
          obs_beats.push_back(q);
          n_valid++;
        end else begin
          check_bit("no_extra_valid", q_valid, 1'b0);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    hold  = 1'b0;
    wr_en = 1'b0;
    check_bit("done_seen", seen_done, 1'b1);
    check_int("valid_beat_count", n_valid, nbeats);
    check_int("done_cycle", done_cyc, nbeats + held);
    @(negedge clk);
    check_bit("idle_after_done", busy, 1'b0);
    check_bit("done_single_pulse", done, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_data = '0;
    start   = 1'b0;
    k_len   = '0;
    hold    = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("rst_q", q, '0);
    check_bit("rst_q_valid", q_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_wr_rej", wr_rej, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_vec("idle_q", q, '0);
    check_bit("idle_busy", busy, 1'b0);
    @(posedge clk); #1;

    // full skew with the 16'h00rc pattern
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < K_MAX; c++)
        write_word(r, c, DATA_W'(r * 16 + c));
    run_stream(4, -1, 0, -1, 1'b0);
    beat3 = 64'h0030_0021_0012_0003;
    check_vec("full_beat3_const", obs_beats[3], beat3);
    check_vec("full_beat0_const", obs_beats[0], QW'(0));
    check_vec("full_beat6_const", obs_beats[6], 64'h0033_0000_0000_0000);

    // short, zero and clamped lengths
    run_stream(2, -1, 0, -1, 1'b0);
    check_vec("k2_beat4_const", obs_beats[4], 64'h0031_0000_0000_0000);
    run_stream(0, -1, 0, -1, 1'b0);
    run_stream(7, -1, 0, -1, 1'b0);

    // random contents from here on
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < K_MAX; c++)
        write_word(r, c, DATA_W'($urandom));

    // hold for 3 cycles while beat 2 is presented
    run_stream(4, 2, 3, -1, 1'b0);

    // write and start while busy are ignored; next stream shows unchanged data
    run_stream(4, -1, 0, 1, 1'b1);
    run_stream(4, -1, 0, -1, 1'b0);

    // write and start on the same edge: stream sees the new word
    wr_en   = 1'b1;
    wr_row  = 2'd0;
    wr_col  = 2'd0;
    wr_data = DATA_W'($urandom);
    ref_mem[0][0] = wr_data;
    run_stream(3, -1, 0, -1, 1'b0);

    // reset asserted at beat 3
    build_expected(4);
    start = 1'b1;
    k_len = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_vec("pre_reset_beat3", q, exp_q[3]);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("mid_rst_q", q, '0);
    check_bit("mid_rst_valid", q_valid, 1'b0);
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("no_done_in_reset", done, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_stream(4, -1, 0, -1, 1'b0);

    // randomized streams with random updates and holds
    for (int it = 0; it < 8; it++) begin
      write_word($urandom_range(0, ROWS - 1), $urandom_range(0, K_MAX - 1), DATA_W'($urandom));
      run_stream($urandom_range(0, 7), $urandom_range(0, 6), $urandom_range(0, 3), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
